// File: rtl/pulse_meter.sv
// pulse_meter: measures the high time and the period of an asynchronous square
// wave in clk cycles and reports one result per full period with a one-cycle
// meas_valid strobe. Counter saturation raises a sticky ovf flag.
//
// Optional build macro PULSE_METER_CHECK_EN adds the EXP_HIGH, EXP_PERIOD and
// TOL parameters and a registered 'match' output. 'match' is set when both
// results lie within +/-TOL of the expected values.
module pulse_meter #(
  parameter int CNT_W      = 25
`ifdef PULSE_METER_CHECK_EN
  ,
  parameter int EXP_HIGH   = 50,
  parameter int EXP_PERIOD = 101,
  parameter int TOL        = 0
`endif
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             ovf
`ifdef PULSE_METER_CHECK_EN
  ,
  output logic             match
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchronizer taps: [0]=s1, [1]=s2 (first safe stage), [2]=s3 (edge history)
  logic [2:0]       sync_q, sync_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hreg_q, hreg_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             ovf_q, ovf_d;
  logic             rise, fall;

`ifdef PULSE_METER_CHECK_EN
  localparam logic [CNT_W-1:0] EXP_HIGH_C   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] EXP_PERIOD_C = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C        = CNT_W'(TOL);

  logic match_q, match_d;

  // Unsigned distance without wrap-around: subtract the smaller from the larger
  function automatic logic within_tol(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] ref_val);
    logic [CNT_W-1:0] diff;
    diff = (val >= ref_val) ? (val - ref_val) : (ref_val - val);
    return (diff <= TOL_C);
  endfunction
`endif

  // Edge detection from the synchronized level
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

  // Next-state and next-result computation
  always_comb begin
    // NOTE: every _d takes its hold value first, so no path leaves a variable unassigned and no latch is inferred.
    sync_d       = {sync_q[1:0], sig_in};
    state_d      = state_q;
    cnt_d        = cnt_q;
    hreg_d       = hreg_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_valid_d = 1'b0;
    ovf_d        = ovf_q;
`ifdef PULSE_METER_CHECK_EN
    match_d      = match_q;
`endif

    if (!start) begin
      // Disable wins over any edge or completion in the same cycle
      state_d = IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
`ifdef PULSE_METER_CHECK_EN
      match_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = WAIT_RISE;
        end

        WAIT_RISE: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = MEAS_HIGH;
          end
        end

        MEAS_HIGH: begin
          if (cnt_q == CNT_MAX) begin
            ovf_d   = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_RISE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (fall) begin
              hreg_d  = cnt_q;
              state_d = MEAS_LOW;
            end
          end
        end

        MEAS_LOW: begin
          if (cnt_q == CNT_MAX) begin
            ovf_d   = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_RISE;
          end else if (rise) begin
            // A rise closes one period and opens the next one immediately
            period_cnt_d = cnt_q;
            high_cnt_d   = hreg_q;
            meas_valid_d = 1'b1;
            cnt_d        = CNT_ONE;
            state_d      = MEAS_HIGH;
`ifdef PULSE_METER_CHECK_EN
            match_d      = within_tol(hreg_q, EXP_HIGH_C) &&
                           within_tol(cnt_q, EXP_PERIOD_C);
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: sequential state uses non-blocking assignments and a reset branch that only loads constants, so the async clear stays glitch-free.
    if (!clr_n) begin
      sync_q       <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      hreg_q       <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef PULSE_METER_CHECK_EN
      match_q      <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hreg_q       <= hreg_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      ovf_q        <= ovf_d;
`ifdef PULSE_METER_CHECK_EN
      match_q      <= match_d;
`endif
    end
  end

  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_valid = meas_valid_q;
  assign ovf        = ovf_q;
`ifdef PULSE_METER_CHECK_EN
  assign match      = match_q;
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// Testbench for pulse_meter. The waveform is described as high/low segment
// lengths. A segment model predicts each completed period and pushes it into a
// scoreboard queue, and a monitor pops one entry per meas_valid strobe.
module tb_pulse_meter;

  localparam int CNT_W  = 8;
  localparam int SAT    = (1 << CNT_W) - 1;
  localparam int EXP_H  = 50;
  localparam int EXP_P  = 101;
  localparam int TOL_TB = 1;

  logic             clk;
  logic             clr_n;
  logic             start;
  logic             sig_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             ovf;
`ifdef PULSE_METER_CHECK_EN
  logic             match;
`endif

  pulse_meter #(
    .CNT_W(CNT_W)
`ifdef PULSE_METER_CHECK_EN
    ,
    .EXP_HIGH(EXP_H),
    .EXP_PERIOD(EXP_P),
    .TOL(TOL_TB)
`endif
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .start(start),
    .sig_in(sig_in),
    .high_cnt(high_cnt),
    .period_cnt(period_cnt),
    .meas_valid(meas_valid),
    .ovf(ovf)
`ifdef PULSE_METER_CHECK_EN
    ,
    .match(match)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h;
    int p;
    bit ov;
    bit m;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Segment model state
  bit have_prev = 0;
  bit cur_seen  = 0;
  int cur_h     = 0;
  int prev_h    = 0;
  int prev_p    = 0;
  bit exp_ovf   = 0;
  int last_h    = 0;
  int last_p    = 0;
  bit prev_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit in_window(input int h, input int p);
    return (iabs(h - EXP_H) <= TOL_TB) && (iabs(p - EXP_P) <= TOL_TB);
  endfunction

  // A rise the armed meter sees closes the previous full period, if any
  task automatic rise_event(input bit seen);
    exp_t e;
    if (have_prev && seen) begin
      if (prev_p >= SAT) begin
        exp_ovf = 1'b1;
      end else begin
        e.h  = prev_h;
        e.p  = prev_p;
        e.ov = exp_ovf;
        e.m  = in_window(prev_h, prev_p);
        sb.push_back(e);
        last_h = prev_h;
        last_p = prev_p;
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // High phase of n cycles; start_at >= 0 raises start inside the phase
  task automatic hi(input int n, input bit seen, input int start_at);
    rise_event(seen);
    cur_h    = n;
    cur_seen = seen;
    sig_in   = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == start_at) start = 1'b1;
      tick(1);
    end
  endtask

  task automatic lo(input int n);
    sig_in = 1'b0;
    tick(n);
    prev_h    = cur_h;
    prev_p    = cur_h + n;
    have_prev = cur_seen;
  endtask

  task automatic arm();
    start = 1'b1;
    tick(4);
  endtask

  task automatic stop();
    start     = 1'b0;
    have_prev = 1'b0;
    cur_seen  = 1'b0;
    exp_ovf   = 1'b0;
    tick(3);
  endtask

  // Monitor: one scoreboard entry per strobe
  always @(negedge clk) begin
    if (clr_n && meas_valid) begin
      check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got high=%0d period=%0d with no result pending",
                 high_cnt, period_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("high_cnt", 32'(high_cnt), e.h);
        check("period_cnt", 32'(period_cnt), e.p);
        check("ovf_at_valid", {31'd0, ovf}, {31'd0, e.ov});
`ifdef PULSE_METER_CHECK_EN
        check("match", {31'd0, match}, {31'd0, e.m});
`endif
      end
    end
    prev_valid = clr_n && meas_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int l;
    clr_n  = 1'b0;
    start  = 1'b0;
    sig_in = 1'b0;
    tick(3);
    check("reset_high_cnt", 32'(high_cnt), 32'd0);
    check("reset_period_cnt", 32'(period_cnt), 32'd0);
    check("reset_meas_valid", {31'd0, meas_valid}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    clr_n = 1'b1;
    tick(3);

    // Nominal 50-high / 51-low timebase
    arm();
    for (int i = 0; i < 4; i++) begin
      hi(50, 1, -1);
      lo(51);
    end
    hi(50, 1, -1);
    check("nominal_ovf", {31'd0, ovf}, 32'd0);
    // Drop start in the middle of the low phase: no result, outputs hold
    lo(20);
    stop();
    lo(31);
    check("stop_hold_high", 32'(high_cnt), last_h);
    check("stop_hold_period", 32'(period_cnt), last_p);
    check("stop_ovf", {31'd0, ovf}, 32'd0);
    check("stop_valid", {31'd0, meas_valid}, 32'd0);
`ifdef PULSE_METER_CHECK_EN
    check("stop_match", {31'd0, match}, 32'd0);
`endif

    // Restart with random waveforms
    arm();
    for (int i = 0; i < 30; i++) begin
      h = int'($urandom_range(1, 60));
      l = int'($urandom_range(1, 60));
      hi(h, 1, -1);
      lo(l);
    end
    hi(5, 1, -1);
    lo(10);
    stop();

    // start asserted while already high: that pulse is not measured
    lo(10);
    hi(20, 0, 5);
    lo(51);
    hi(50, 1, -1);
    lo(51);
    hi(50, 1, -1);
    lo(51);
    hi(10, 1, -1);
    lo(10);
    stop();

    // Counter saturation, then recovery with ovf held
    arm();
    hi(300, 1, -1);
    check("sat_ovf_set", {31'd0, ovf}, 32'd1);
    lo(10);
    for (int i = 0; i < 4; i++) begin
      hi(10, 1, -1);
      lo(10);
    end
    hi(10, 1, -1);
    check("sat_ovf_sticky", {31'd0, ovf}, 32'd1);
    lo(10);
    stop();
    check("sat_ovf_cleared", {31'd0, ovf}, 32'd0);

    // Window check values around the expected timebase
    arm();
    hi(51, 1, -1);
    lo(50);
    hi(53, 1, -1);
    lo(48);
    hi(50, 1, -1);
    lo(52);
    hi(10, 1, -1);
    lo(10);
    stop();

    // Async reset in the middle of a high phase
    arm();
    hi(50, 1, -1);
    lo(51);
    hi(20, 1, -1);
    clr_n = 1'b0;
    start = 1'b0;
    #1;
    check("clr_high_cnt", 32'(high_cnt), 32'd0);
    check("clr_period_cnt", 32'(period_cnt), 32'd0);
    check("clr_meas_valid", {31'd0, meas_valid}, 32'd0);
    check("clr_ovf", {31'd0, ovf}, 32'd0);
`ifdef PULSE_METER_CHECK_EN
    check("clr_match", {31'd0, match}, 32'd0);
`endif
    have_prev = 1'b0;
    cur_seen  = 1'b0;
    last_h    = 0;
    last_p    = 0;
    tick(3);
    clr_n = 1'b1;
    tick(30);
    lo(20);
    check("post_clr_hold_high", 32'(high_cnt), 32'd0);
    arm();
    hi(10, 1, -1);
    lo(15);
    hi(12, 1, -1);
    lo(9);
    hi(5, 1, -1);
    lo(10);
    stop();

    tick(10);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Receiving end of the periodic timing-pulse interface: measures high time and period of an incoming square wave in clk cycles.
- Sits downstream of the pulse generator; used to check generated timebases (e.g. 50-high/51-low waveform) and to feed period data to display/control logic.
- One result per full period, presented with a 1-cycle valid strobe.

Parameters:
- CNT_W, 25, width of internal counter and result registers.
- EXP_HIGH, 50, expected high count (optional check only).
- EXP_PERIOD, 101, expected period count (optional check only).
- TOL, 0, allowed ± deviation for optional check.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- start  in  1  measurement enable; level-sensitive.
- sig_in  in  1  asynchronous waveform under measurement.
- high_cnt  out  CNT_W  clk cycles sig was high in last completed period.
- period_cnt  out  CNT_W  clk cycles from rise to next rise.
- meas_valid  out  1  1-cycle strobe; high_cnt/period_cnt updated this cycle.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (clr_n=0, async): all regs 0; state IDLE; high_cnt=0, period_cnt=0, meas_valid=0, ovf=0.
- Input sync: sig_in through 2 FFs (s1, s2), plus s3 for edge detect. rise = s2 & ~s3; fall = ~s2 & s3. Edge detect lags sig_in by 2–3 cycles; widths unaffected.
- States: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
- IDLE: cnt=0. start=1 -> WAIT_RISE.
- WAIT_RISE: ignores level; first rise -> cnt<=1, MEAS_HIGH. Signal already high when start asserts is not measured until the next rise.
- MEAS_HIGH: cnt<=cnt+1 each cycle; on fall: internal high register<=cnt, cnt<=cnt+1, -> MEAS_LOW.
- MEAS_LOW: cnt<=cnt+1; on rise: period_cnt<=cnt, high_cnt<=internal high register, meas_valid<=1 next cycle, cnt<=1, -> MEAS_HIGH (back-to-back periods measured continuously).
- Count definition: during cycle r+k after rise sampled at r, cnt=k. 50 high + 51 low samples -> high_cnt=50, period_cnt=101.
- Saturation: if cnt == 2^CNT_W-1 in MEAS_HIGH or MEAS_LOW, ovf<=1, cnt<=0, -> WAIT_RISE; outputs not updated, no meas_valid.
- ovf sticky; cleared only by reset or start=0.
- start=0 in any state: next cycle -> IDLE, cnt=0, ovf=0, meas_valid=0; high_cnt/period_cnt hold last values. start=0 has priority over a simultaneous edge or completion.
- meas_valid is exactly one cycle per completed period; never two consecutive cycles (minimum period ≥ 2 cycles after sync).
- Reset mid-measurement: immediate return to reset values; no partial result emitted.

Optional Feature:
- Macro PULSE_METER_CHECK_EN.
- Defined: adds output port match (1 bit, reset 0). Updated with meas_valid: match<=1 iff |high_cnt−EXP_HIGH|≤TOL and |period_cnt−EXP_PERIOD|≤TOL (unsigned compare, no wrap); holds until next meas_valid; cleared with start=0.
- Not defined: port and compare logic absent; all other behaviour identical.

Test Plan:
- Drive 50-high/51-low waveform, start=1 -> first meas_valid after second rise; high_cnt=50, period_cnt=101; repeats every 101 cycles, ovf=0.
- Assert start while sig_in high for 20 more cycles -> that partial pulse ignored; first result still 50/101.
- CNT_W=8, sig_in held high 300 cycles -> ovf=1 at cnt=255, no meas_valid; later 10/20 waveform -> valid results 10/20, ovf stays 1 until start=0.
- start=0 mid-MEAS_LOW after one result 50/101 -> no meas_valid, outputs hold 50/101, ovf=0; restart -> new results resume after next full period.
- clr_n pulsed low mid-MEAS_HIGH -> all outputs 0 immediately, state IDLE; after release, measurement restarts only with start=1 and a rise.
- PULSE_METER_CHECK_EN, TOL=1: waveform 51/101 -> match=1; 53/101 -> match=0.
